dll_tx_arbiter: RTL and testbench

Sequences the DLL transmit datapath toward the PIPE/EP side. Shares the single dll2pipe beat stream between the TLP path (packetizer output) and the DLLP generator (InitFC/UpdateFC/Ack/Nak). Gates each source by DLCMSM state and never interleaves DLLPs inside a TLP. It sits between the packetizer, the DLLP generator and the dll2pipe output register inside DLL_TOP.

---
 rtl/dll_pkg.sv | 19 +
 rtl/dll_tx_arbiter_if.sv | 29 ++
 rtl/dll_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_dll_tx_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dll_pkg.sv
// Shared DLL types: DLCMSM link states and the tx arbiter FSM encoding.
package dll_pkg;

    localparam int unsigned DLL_PIPE_DATA_WIDTH = 256;
    localparam int unsigned DLL_MAX_DLLP_BURST  = 4;

    typedef enum logic [1:0] {
        INACTIVE = 2'd0,
        INIT1    = 2'd1,
        INIT2    = 2'd2,
        ACTIVE   = 2'd3
    } dlcm_state_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_TLP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dll_tx_arbiter_if.sv
// Beat streams into the tx arbiter (DLLP, TLP) and the registered dll2pipe output.
interface dll_tx_arbiter_if
    import dll_pkg::*;
#(
    parameter int unsigned PIPE_DATA_WIDTH = DLL_PIPE_DATA_WIDTH
);

    logic                       dllp_valid;
    logic [PIPE_DATA_WIDTH-1:0] dllp_data;
    logic                       dllp_ready;
    logic                       tlp_valid;
    logic                       tlp_sop;
    logic                       tlp_eop;
    logic [PIPE_DATA_WIDTH-1:0] tlp_data;
    logic                       tlp_ready;
    logic [PIPE_DATA_WIDTH-1:0] dll2pipe_data;
    logic                       dll2pipe_valid;

    modport slave (
        input  dllp_valid, dllp_data, tlp_valid, tlp_sop, tlp_eop, tlp_data,
        output dllp_ready, tlp_ready, dll2pipe_data, dll2pipe_valid
    );

    modport master (
        output dllp_valid, dllp_data, tlp_valid, tlp_sop, tlp_eop, tlp_data,
        input  dllp_ready, tlp_ready, dll2pipe_data, dll2pipe_valid
    );

endinterface

// File: rtl/dll_tx_arbiter.sv
// Shares the dll2pipe beat stream between TLPs and DLLPs, gated by DLCMSM state,
// never splitting a TLP and bounding DLLP bursts while a TLP waits.
module dll_tx_arbiter
    import dll_pkg::*;
#(
    parameter int unsigned PIPE_DATA_WIDTH = DLL_PIPE_DATA_WIDTH,
    parameter int unsigned MAX_DLLP_BURST  = DLL_MAX_DLLP_BURST
) (
    input  logic                   sclk,
    input  logic                   srst,
    input  dlcm_state_t            dlcm_state_i,
    dll_tx_arbiter_if.slave        tx_io,
    output logic                   tlp_abort_o,
    output logic                   proto_err_o
);

    localparam int unsigned CntW = $clog2(MAX_DLLP_BURST + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_DLLP_BURST);

    arb_state_t                 state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [PIPE_DATA_WIDTH-1:0] data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       abort_q, abort_d;
    logic                       err_q, err_d;
    logic                       dllp_rdy, tlp_rdy, tlp_gnt, link_drop;

    always_comb begin
        dllp_rdy  = 1'b0;
        tlp_rdy   = 1'b0;
        state_d   = state_q;
        data_d    = '0;
        valid_d   = 1'b0;
        abort_d   = 1'b0;
        err_d     = 1'b0;
        link_drop = 1'b0;

        unique case (state_q)
            IDLE: begin
                unique case (dlcm_state_i)
                    INACTIVE: ;
                    INIT1, INIT2: dllp_rdy = tx_io.dllp_valid;
                    ACTIVE: begin
                        if (tx_io.dllp_valid && (!tx_io.tlp_valid || cnt_q < MaxCnt)) begin
                            dllp_rdy = 1'b1;
                        end else begin
                            tlp_rdy = tx_io.tlp_valid;
                        end
                    end
                endcase
                // A beat without sop outside a packet is swallowed and flagged.
                if (tlp_rdy && tx_io.tlp_valid) begin
                    if (tx_io.tlp_sop) begin
                        data_d  = tx_io.tlp_data;
                        valid_d = 1'b1;
                        if (!tx_io.tlp_eop) state_d = IN_TLP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            IN_TLP: begin
                if (dlcm_state_i != ACTIVE) begin
                    link_drop = 1'b1;
                    abort_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tlp_rdy = 1'b1;
                    if (tx_io.tlp_valid) begin
                        data_d  = tx_io.tlp_data;
                        valid_d = 1'b1;
                        err_d   = tx_io.tlp_sop;
                        if (tx_io.tlp_eop) state_d = IDLE;
                    end
                end
            end
        endcase

        if (dllp_rdy) begin
            data_d  = tx_io.dllp_data;
            valid_d = 1'b1;
        end
    end

    assign tlp_gnt = tlp_rdy && tx_io.tlp_valid;

    // Burst counter only tracks DLLPs granted while a TLP is kept waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (tlp_gnt || !tx_io.tlp_valid || link_drop) begin
            cnt_d = '0;
        end else if (dllp_rdy && cnt_q < MaxCnt) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end

    assign tx_io.dllp_ready     = dllp_rdy;
    assign tx_io.tlp_ready      = tlp_rdy;
    assign tx_io.dll2pipe_data  = data_q;
    assign tx_io.dll2pipe_valid = valid_q;
    assign tlp_abort_o          = abort_q;
    assign proto_err_o          = err_q;

endmodule

// File: tb/tb_dll_tx_arbiter.sv
// Directed and randomized bench for dll_tx_arbiter against a cycle-level reference model.
module tb_dll_tx_arbiter;
    import dll_pkg::*;

    localparam int unsigned W   = 256;
    localparam int unsigned MAX = 4;

    logic        sclk = 1'b0;
    logic        srst;
    dlcm_state_t dlcm;
    logic        tlp_abort, proto_err;

    dll_tx_arbiter_if #(.PIPE_DATA_WIDTH(W)) bus ();

    dll_tx_arbiter #(
        .PIPE_DATA_WIDTH(W),
        .MAX_DLLP_BURST (MAX)
    ) dut (
        .sclk        (sclk),
        .srst        (srst),
        .dlcm_state_i(dlcm),
        .tx_io       (bus),
        .tlp_abort_o (tlp_abort),
        .proto_err_o (proto_err)
    );

    always #5 sclk = ~sclk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: whether a packet is open, how many DLLPs have jumped a waiting TLP,
    // and the output expected to be visible now.
    bit         m_open;
    int         m_jumps;
    logic [W-1:0] e_data;
    logic       e_valid, e_abort, e_err;

    // Observed event tallies for directed end-of-scenario checks.
    int o_beats, o_aborts, o_errs, o_tlp_gnts, o_tlp_rdy;

    function automatic logic [W-1:0] rnd_beat();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clr_obs();
        o_beats = 0; o_aborts = 0; o_errs = 0; o_tlp_gnts = 0; o_tlp_rdy = 0;
    endtask

    task automatic drive(input bit rst, input int unsigned ds, input bit dv, input bit tv,
                         input bit sop, input bit eop);
        srst           = rst;
        dlcm           = dlcm_state_t'(ds[1:0]);
        bus.dllp_valid = dv;
        bus.dllp_data  = rnd_beat();
        bus.tlp_valid  = tv;
        bus.tlp_sop    = sop;
        bus.tlp_eop    = eop;
        bus.tlp_data   = rnd_beat();
    endtask

    task automatic step();
        bit x_dr, x_tr, link_up, tv, dv, dllp_gnt, tlp_gnt;
        @(negedge sclk);
        link_up = (dlcm == ACTIVE);
        tv      = bus.tlp_valid;
        dv      = bus.dllp_valid;
        x_dr    = 1'b0;
        x_tr    = 1'b0;
        if (m_open) begin
            x_tr = link_up;
        end else if (dlcm == INIT1 || dlcm == INIT2) begin
            x_dr = dv;
        end else if (link_up) begin
            x_dr = dv && (!tv || m_jumps < MAX);
            x_tr = tv && !x_dr;
        end

        chk("dllp_ready", bus.dllp_ready, x_dr);
        chk("tlp_ready", bus.tlp_ready, x_tr);
        chk("out_valid", bus.dll2pipe_valid, e_valid);
        chk("out_data", bus.dll2pipe_data, e_data);
        chk("tlp_abort", tlp_abort, e_abort);
        chk("proto_err", proto_err, e_err);

        o_beats    += int'(bus.dll2pipe_valid);
        o_aborts   += int'(tlp_abort);
        o_errs     += int'(proto_err);
        o_tlp_rdy  += int'(bus.tlp_ready);
        o_tlp_gnts += int'(bus.tlp_ready && tv);

        dllp_gnt = x_dr;
        tlp_gnt  = x_tr && tv;
        e_data   = '0;
        e_valid  = 1'b0;
        e_abort  = 1'b0;
        e_err    = 1'b0;
        if (srst) begin
            m_open  = 1'b0;
            m_jumps = 0;
        end else if (m_open && !link_up) begin
            m_open  = 1'b0;
            m_jumps = 0;
            e_abort = 1'b1;
        end else if (dllp_gnt) begin
            e_valid = 1'b1;
            e_data  = bus.dllp_data;
            m_jumps = tv ? ((m_jumps + 1 > MAX) ? MAX : m_jumps + 1) : 0;
        end else if (tlp_gnt) begin
            m_jumps = 0;
            if (m_open || bus.tlp_sop) begin
                e_valid = 1'b1;
                e_data  = bus.tlp_data;
            end
            e_err  = (m_open == bus.tlp_sop);
            m_open = m_open ? !bus.tlp_eop : (bus.tlp_sop && !bus.tlp_eop);
        end else if (!tv) begin
            m_jumps = 0;
        end
        @(posedge sclk);
        #1;
    endtask

    initial begin
        drive(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge sclk);
        @(posedge sclk);
        #1;
        m_open = 1'b0; m_jumps = 0;
        e_data = '0; e_valid = 1'b0; e_abort = 1'b0; e_err = 1'b0;

        // Reset state with link inactive and nothing offered
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // INIT1: DLLPs flow, TLP never granted
        clr_obs();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("init1_beats", o_beats, 3);
        chk("init1_tlp_rdy", o_tlp_rdy, 0);

        // ACTIVE 4-beat TLP, DLLP raised at beat1 waits until after eop
        clr_obs();
        drive(1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b0); step();
        drive(1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b1); step();
        drive(1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0); step();
        chk("tlp4_beats", o_beats, 5);

        // Continuous DLLP + single-beat TLP pressure: TLP wins every fifth cycle
        clr_obs();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b1);
            step();
        end
        chk("burst_tlp_gnts", o_tlp_gnts, 2);
        drive(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0); step();

        // Link drop on beat 2 of a 3-beat TLP
        clr_obs();
        drive(1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b0); step();
        drive(1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1); step();
        drive(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        chk("drop_aborts", o_aborts, 1);
        chk("drop_beats", o_beats, 2);

        // Stray non-sop beat dropped with error, then single-beat TLP forwarded
        clr_obs();
        drive(1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b1); step();
        drive(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0); step();
        chk("stray_errs", o_errs, 1);
        chk("stray_beats", o_beats, 1);

        // Reset mid-TLP: output clears, no abort
        clr_obs();
        drive(1'b0, 3, 1'b0, 1'b1, 1'b1, 1'b0); step();
        drive(1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0); step();
        chk("rst_aborts", o_aborts, 0);
        chk("rst_beats", o_beats, 3);

        // Randomized traffic, link mostly ACTIVE, rare resets
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 63) == 0,
                  ($urandom_range(0, 9) < 8) ? 3 : $urandom_range(0, 2),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
